// File: rtl/riscv_mult_arb.sv
// riscv_mult_arb
// Round-robin arbiter/sequencer sharing one riscv_mult between NREQ requesters.
// A winning request is latched in IDLE. The operands are held on the multiplier
// interface for the whole operation, including the multi-cycle MUL_H sequence.
// The result is returned on a per-requester valid/ready response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready is a one-hot accept pulse)
//   req_operator_i, req_op_{a,b,c}_i, req_signed_i, req_subword_i, req_imm_i
//                            flattened per-requester request fields
//   rsp_valid_o/rsp_ready_i  response handshake, routed to the owning requester
//   rsp_result_o             shared 32-bit result bus
//   flush_i                  discard the response of the in-flight operation
//   busy_o                   arbiter not idle
//   mult_*                   connection to riscv_mult (the multiplier's rst_n = ~rst)
module riscv_mult_arb #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*3-1:0]    req_operator_i,
    input  logic [NREQ*32-1:0]   req_op_a_i,
    input  logic [NREQ*32-1:0]   req_op_b_i,
    input  logic [NREQ*32-1:0]   req_op_c_i,
    input  logic [NREQ*2-1:0]    req_signed_i,
    input  logic [NREQ-1:0]      req_subword_i,
    input  logic [NREQ*5-1:0]    req_imm_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [31:0]          rsp_result_o,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 mult_enable_o,
    output logic [2:0]           mult_operator_o,
    output logic [31:0]          mult_op_a_o,
    output logic [31:0]          mult_op_b_o,
    output logic [31:0]          mult_op_c_o,
    output logic [1:0]           mult_signed_o,
    output logic                 mult_subword_o,
    output logic [4:0]           mult_imm_o,
    input  logic                 mult_ready_i,
    input  logic [31:0]          mult_result_i,
    output logic                 mult_ex_ready_o
);

    localparam int IDW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0]  owner_reg, owner_next;
    logic [2:0]      op_reg, op_next;
    logic [31:0]     a_reg, a_next;
    logic [31:0]     b_reg, b_next;
    logic [31:0]     c_reg, c_next;
    logic [1:0]      sgn_reg, sgn_next;
    logic            sub_reg, sub_next;
    logic [4:0]      imm_reg, imm_next;
    logic [31:0]     result_reg, result_next;
    logic            drop_reg, drop_next;

    // Per-requester views of the flattened request buses
    logic [2:0]  req_op  [NREQ];
    logic [31:0] req_a   [NREQ];
    logic [31:0] req_b   [NREQ];
    logic [31:0] req_c   [NREQ];
    logic [1:0]  req_sgn [NREQ];
    logic [4:0]  req_imm [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
            assign req_op[gi]  = req_operator_i[gi*3 +: 3];
            assign req_a[gi]   = req_op_a_i[gi*32 +: 32];
            assign req_b[gi]   = req_op_b_i[gi*32 +: 32];
            assign req_c[gi]   = req_op_c_i[gi*32 +: 32];
            assign req_sgn[gi] = req_signed_i[gi*2 +: 2];
            assign req_imm[gi] = req_imm_i[gi*5 +: 5];
        end
    endgenerate

    // First valid requester at or after the round-robin pointer, wrapping
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;

    always_comb begin
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_reg) + k) % NREQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        owner_next      = owner_reg;
        op_next         = op_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        c_next          = c_reg;
        sgn_next        = sgn_reg;
        sub_next        = sub_reg;
        imm_next        = imm_reg;
        result_next     = result_reg;
        drop_next       = drop_reg;
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        mult_ex_ready_o = 1'b0;

        case (state_reg)
            IDLE: begin
                // No accept while reset is asserted: the latch would be lost
                if (grant_found && !rst) begin
                    req_ready_o[grant_idx] = 1'b1;
                    owner_next  = grant_idx;
                    op_next     = req_op[grant_idx];
                    a_next      = req_a[grant_idx];
                    b_next      = req_b[grant_idx];
                    c_next      = req_c[grant_idx];
                    sgn_next    = req_sgn[grant_idx];
                    sub_next    = req_subword_i[grant_idx];
                    imm_next    = req_imm[grant_idx];
                    rr_ptr_next = IDW'((int'(grant_idx) + 1) % NREQ);
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                // The multiplier cannot be aborted; a flush only drops the response
                if (flush_i) begin
                    drop_next = 1'b1;
                end
                if (mult_ready_i) begin
                    mult_ex_ready_o = 1'b1;
                    if (drop_reg || flush_i) begin
                        state_next = IDLE;
                    end else begin
                        result_next = mult_result_i;
                        state_next  = RESP;
                    end
                end
            end
            RESP: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    rsp_valid_o[owner_reg] = 1'b1;
                    if (rsp_ready_i[owner_reg]) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == IDLE) begin
            drop_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            sgn_reg    <= '0;
            sub_reg    <= 1'b0;
            imm_reg    <= '0;
            result_reg <= '0;
            drop_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            c_reg      <= c_next;
            sgn_reg    <= sgn_next;
            sub_reg    <= sub_next;
            imm_reg    <= imm_next;
            result_reg <= result_next;
            drop_reg   <= drop_next;
        end
    end

    assign busy_o          = (state_reg != IDLE);
    assign mult_enable_o   = (state_reg == ISSUE);
    assign mult_operator_o = op_reg;
    assign mult_op_a_o     = a_reg;
    assign mult_op_b_o     = b_reg;
    assign mult_op_c_o     = c_reg;
    assign mult_signed_o   = sgn_reg;
    assign mult_subword_o  = sub_reg;
    assign mult_imm_o      = imm_reg;
    assign rsp_result_o    = result_reg;

    a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready_o));
    a_rsp_onehot0   : assert property (@(posedge clk) $onehot0(rsp_valid_o));
    a_issue_stable  : assert property (@(posedge clk) disable iff (rst)
        (state_reg == ISSUE && $past(state_reg) == ISSUE) |->
        $stable({mult_operator_o, mult_op_a_o, mult_op_b_o, mult_op_c_o,
                 mult_signed_o, mult_subword_o, mult_imm_o}));
    a_ex_ready      : assert property (@(posedge clk)
        mult_ex_ready_o |-> (state_reg == ISSUE && mult_ready_i));

endmodule

// File: tb/tb_riscv_mult_arb.sv
// Bench for riscv_mult_arb: a behavioural multiplier stand-in plus a
// transaction-level reference model (grant order, latency, result routing).
module tb_riscv_mult_arb;

    localparam int NREQ = 2;
    localparam logic [2:0] OP_MAC32 = 3'd0;
    localparam logic [2:0] OP_H     = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*3-1:0]  req_operator;
    logic [NREQ*32-1:0] req_op_a, req_op_b, req_op_c;
    logic [NREQ*2-1:0]  req_signed;
    logic [NREQ-1:0]    req_subword;
    logic [NREQ*5-1:0]  req_imm;
    logic [31:0]        rsp_result;
    logic               flush, busy, mult_enable, mult_subword, mult_ready, mult_ex_ready;
    logic [2:0]         mult_operator;
    logic [31:0]        mult_op_a, mult_op_b, mult_op_c, mult_result;
    logic [1:0]         mult_signed;
    logic [4:0]         mult_imm;

    logic [2:0]  r_op  [NREQ];
    logic [31:0] r_a   [NREQ];
    logic [31:0] r_b   [NREQ];
    logic [31:0] r_c   [NREQ];
    logic [1:0]  r_sg  [NREQ];
    logic        r_sub [NREQ];
    logic [4:0]  r_imm [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_operator[gi*3 +: 3] = r_op[gi];
        assign req_op_a[gi*32 +: 32]   = r_a[gi];
        assign req_op_b[gi*32 +: 32]   = r_b[gi];
        assign req_op_c[gi*32 +: 32]   = r_c[gi];
        assign req_signed[gi*2 +: 2]   = r_sg[gi];
        assign req_subword[gi]         = r_sub[gi];
        assign req_imm[gi*5 +: 5]      = r_imm[gi];
    end

    riscv_mult_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operator_i(req_operator),
        .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_op_c_i(req_op_c),
        .req_signed_i(req_signed), .req_subword_i(req_subword), .req_imm_i(req_imm),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .flush_i(flush), .busy_o(busy),
        .mult_enable_o(mult_enable), .mult_operator_o(mult_operator),
        .mult_op_a_o(mult_op_a), .mult_op_b_o(mult_op_b), .mult_op_c_o(mult_op_c),
        .mult_signed_o(mult_signed), .mult_subword_o(mult_subword), .mult_imm_o(mult_imm),
        .mult_ready_i(mult_ready), .mult_result_i(mult_result),
        .mult_ex_ready_o(mult_ex_ready)
    );

    // Arithmetic meaning of each operator as far as this bench is concerned
    function automatic logic [31:0] mul_func(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c,
                                             input logic [1:0] sg, input logic sub,
                                             input logic [4:0] imm);
        logic signed [32:0] ea, eb;
        logic signed [65:0] p;
        ea = {sg[0] & a[31], a};
        eb = {sg[1] & b[31], b};
        p  = ea * eb;
        case (op)
            3'd0:    mul_func = a * b + c;
            3'd1:    mul_func = c - a * b;
            3'd6:    mul_func = p[63:32];
            default: mul_func = (a ^ {b[15:0], b[31:16]}) + c + {24'd0, sg, sub, imm};
        endcase
    endfunction

    // Multiplier stand-in: single-cycle ops ready at once; MUL_H walks
    // IDLE, STEP0, STEP1, STEP2, FINISH and is ready in FINISH.
    logic [2:0] mh_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            mh_cnt <= 3'd0;
        end else if (mult_enable && mult_operator == OP_H) begin
            if (mh_cnt != 3'd4) mh_cnt <= mh_cnt + 3'd1;
            else if (mult_ex_ready) mh_cnt <= 3'd0;
        end
    end
    assign mult_ready  = mult_enable && ((mult_operator != OP_H) || (mh_cnt == 3'd4));
    assign mult_result = mul_func(mult_operator, mult_op_a, mult_op_b, mult_op_c,
                                  mult_signed, mult_subword, mult_imm);

    // ---------------- bookkeeping and reference model ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit pend = 0, drop = 0, rst_prev = 0;
    int p_acc = 0, p_lat = 0, p_owner = 0, ptr = 0, first_rsp = -1;
    logic [31:0] p_res = '0, p_a = '0, p_b = '0, p_c = '0, last_res = '0;
    logic [2:0]  p_op = '0;
    logic [7:0]  p_misc = '0;
    int acc_cnt [NREQ];
    int drv_seen [NREQ];
    int done_cnt = 0, drop_cnt = 0, flushed_cnt = 0, ex_cnt = 0;
    logic [31:0] done_res = '0;
    int done_owner = 0, done_lat = 0;
    int grant_q[$];
    int grant_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle of observation at the falling edge, then advance to just after
    // the next rising edge where the stimulus for the following cycle is set.
    task automatic tick();
        logic [NREQ-1:0] exp_grant, exp_rsp;
        bit in_issue, in_resp;
        int w;
        @(negedge clk);
        cyc++;
        in_issue  = pend && cyc > p_acc && cyc < p_acc + p_lat;
        in_resp   = pend && cyc >= p_acc + p_lat;
        exp_grant = '0;
        exp_rsp   = '0;
        w = -1;
        if (!rst && !pend) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req_valid[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        end
        if (w >= 0) exp_grant[w] = 1'b1;
        if (in_resp && !flush) exp_rsp[p_owner] = 1'b1;

        chk("req_ready", 32'(req_ready), 32'(exp_grant));
        chk("busy", 32'(busy), 32'(pend));
        chk("mult_enable", 32'(mult_enable), 32'(in_issue));
        chk("ex_ready", 32'(mult_ex_ready), 32'(in_issue && cyc == p_acc + p_lat - 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        chk("rsp_result", rsp_result, last_res);
        if (in_issue) begin
            chk("mult_op", 32'(mult_operator), 32'(p_op));
            chk("mult_a", mult_op_a, p_a);
            chk("mult_b", mult_op_b, p_b);
            chk("mult_c", mult_op_c, p_c);
            chk("mult_misc", 32'({mult_signed, mult_subword, mult_imm}), 32'(p_misc));
        end
        if (rst_prev) begin
            chk("rst_mult_data", {mult_op_a | mult_op_b | mult_op_c},  32'd0);
            chk("rst_mult_misc", 32'({mult_operator, mult_signed, mult_subword, mult_imm}), 32'd0);
        end
        if (mult_ex_ready) ex_cnt++;
        if (pend && rsp_valid != '0 && first_rsp < 0) first_rsp = cyc;

        rst_prev = rst;
        if (rst) begin
            pend = 0; drop = 0; ptr = 0; last_res = '0;
        end else begin
            if (in_issue) begin
                if (flush) drop = 1;
                if (cyc == p_acc + p_lat - 1) begin
                    if (drop) begin
                        pend = 0; drop_cnt++;
                        $display("txn owner=%0d op=%0d accept=%0d dropped by flush in issue", p_owner, p_op, p_acc);
                    end else begin
                        last_res = p_res;
                    end
                end
            end else if (in_resp) begin
                if (flush) begin
                    pend = 0; flushed_cnt++;
                    $display("txn owner=%0d op=%0d accept=%0d response flushed", p_owner, p_op, p_acc);
                end else if (rsp_ready[p_owner]) begin
                    pend = 0; done_cnt++;
                    done_res = rsp_result; done_owner = p_owner; done_lat = first_rsp - p_acc;
                    $display("txn owner=%0d op=%0d accept=%0d latency=%0d result=0x%08h",
                             p_owner, p_op, p_acc, done_lat, rsp_result);
                end
            end
            if (w >= 0) begin
                pend = 1; drop = 0; p_acc = cyc; p_owner = w; first_rsp = -1;
                p_op = r_op[w]; p_a = r_a[w]; p_b = r_b[w]; p_c = r_c[w];
                p_misc = {r_sg[w], r_sub[w], r_imm[w]};
                p_lat = (r_op[w] == OP_H) ? 6 : 2;
                p_res = mul_func(r_op[w], r_a[w], r_b[w], r_c[w], r_sg[w], r_sub[w], r_imm[w]);
                ptr = (w + 1) % NREQ;
                acc_cnt[w]++;
                grant_q.push_back(w);
                grant_cyc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input logic [1:0] sg);
        r_op[r] = op; r_a[r] = a; r_b[r] = b; r_c[r] = c; r_sg[r] = sg;
        r_sub[r] = 1'b0; r_imm[r] = 5'd0;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_acc(input int r);
        int n = 0;
        while (acc_cnt[r] == drv_seen[r] && n < 60) begin
            tick();
            n++;
        end
        chk("accept_timeout", 32'(acc_cnt[r] != drv_seen[r]), 32'd1);
        drv_seen[r] = acc_cnt[r];
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pend && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(pend), 32'd0);
    endtask

    task automatic do_req(input int r, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [1:0] sg);
        set_req(r, op, a, b, c, sg);
        wait_acc(r);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d0, dr0, gq0;
        req_valid = '0; rsp_ready = '1; flush = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; r_c[i] = '0;
            r_sg[i] = '0; r_sub[i] = 1'b0; r_imm[i] = '0;
            acc_cnt[i] = 0; drv_seen[i] = 0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", 32'({req_ready, rsp_valid, busy, mult_enable, mult_ex_ready}), 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single-cycle MAC32 from requester 0
        e0 = ex_cnt;
        do_req(0, OP_MAC32, 32'd3, 32'd5, 32'd7, 2'b00);
        chk("mac_result", done_res, 32'd22);
        chk("mac_latency", 32'(done_lat), 32'd2);
        chk("mac_owner", 32'(done_owner), 32'd0);
        chk("mac_ex_pulses", 32'(ex_cnt - e0), 32'd1);

        // MUL_H from requester 1 with each signedness combination
        do_req(1, OP_H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b00);
        chk("mulhu_result", done_res, 32'hFFFF_FFFE);
        chk("mulh_latency", 32'(done_lat), 32'd6);
        chk("mulh_owner", 32'(done_owner), 32'd1);
        do_req(1, OP_H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b11);
        chk("mulh_ss_result", done_res, 32'h0000_0000);
        do_req(1, OP_H, 32'h8000_0000, 32'd2, 32'd0, 2'b01);
        chk("mulhsu_result", done_res, 32'hFFFF_FFFF);

        // Both requesters continuously valid: alternating grants, 3 cycles apart
        gq0 = grant_q.size();
        set_req(0, OP_MAC32, 32'd11, 32'd12, 32'd13, 2'b00);
        set_req(1, OP_MAC32, 32'd21, 32'd22, 32'd23, 2'b00);
        for (int i = 0; i < 14; i++) tick();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) drv_seen[i] = acc_cnt[i];
        wait_idle();
        chk("alt_grant_count", 32'(grant_q.size() - gq0 >= 4), 32'd1);
        if (grant_q.size() - gq0 >= 4) begin
            for (int i = 0; i < 4; i++) chk("alt_owner", 32'(grant_q[gq0 + i]), 32'(i % 2));
            for (int i = 1; i < 4; i++)
                chk("alt_spacing", 32'(grant_cyc_q[gq0 + i] - grant_cyc_q[gq0 + i - 1]), 32'd3);
        end

        // Response back-pressure: valid and result held, nobody else granted
        rsp_ready[0] = 1'b0;
        set_req(0, OP_MAC32, 32'd9, 32'd9, 32'd1, 2'b00);
        wait_acc(0);
        set_req(1, OP_MAC32, 32'd1, 32'd1, 32'd1, 2'b00);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'b01);
            chk("hold_rsp_result", rsp_result, 32'd82);
            chk("hold_no_grant", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        wait_acc(1);
        wait_idle();

        // Flush during MUL_H: op completes, one ex_ready, no response
        e0 = ex_cnt; d0 = done_cnt; dr0 = drop_cnt;
        set_req(0, OP_H, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 2'b00);
        wait_acc(0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle();
        chk("flush_dropped", 32'(drop_cnt - dr0), 32'd1);
        chk("flush_no_rsp", 32'(done_cnt - d0), 32'd0);
        chk("flush_ex_pulses", 32'(ex_cnt - e0), 32'd1);
        do_req(0, OP_H, 32'h0001_0000, 32'h0001_0000, 32'd0, 2'b00);
        chk("after_flush_result", done_res, 32'h0000_0001);

        // Reset in cycle 3 of a MUL_H
        set_req(1, OP_H, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd0, 2'b11);
        wait_acc(1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outputs", 32'({req_ready, rsp_valid, busy, mult_enable, mult_ex_ready}), 32'd0);
        chk("midrst_result", rsp_result, 32'd0);
        chk("midrst_mult_a", mult_op_a, 32'd0);
        do_req(0, OP_MAC32, 32'd2, 32'd2, 32'd0, 2'b00);
        chk("after_rst_result", done_res, 32'd4);

        // Randomized traffic with back-pressure, flushes and occasional resets
        d0 = done_cnt;
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_cnt[i] != drv_seen[i]) begin
                    drv_seen[i] = acc_cnt[i];
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    r_op[i]  = 3'($urandom_range(0, 6));
                    r_a[i]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    r_b[i]   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                    r_c[i]   = $urandom;
                    r_sg[i]  = 2'($urandom_range(0, 3));
                    r_sub[i] = 1'($urandom_range(0, 1));
                    r_imm[i] = 5'($urandom_range(0, 31));
                    req_valid[i] = 1'b1;
                end
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            flush = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            tick();
        end
        req_valid = '0; flush = 1'b0; rst = 1'b0; rsp_ready = '1;
        tick();
        wait_idle();
        chk("random_progress", 32'(done_cnt - d0 > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
